// File: rtl/queue_drain_pkg.sv
// ----------------------------------------------------------------------------
// queue_drain_pkg
//   Shared types and defaults for the queue drain controller.
//   - drain_state_t   : FSM state encoding (IDLE, FETCH, CAPT, POP, HOLD)
//   - DEF_BITWIDTH    : default queue word width, shared with the queue
//   - DEF_QUEUESIZE   : default queue depth, shared with the queue
//   - cnt_width()     : width of a counter able to hold 0..depth
// ----------------------------------------------------------------------------
package queue_drain_pkg;

    localparam int DEF_BITWIDTH  = 3;
    localparam int DEF_QUEUESIZE = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        CAPT  = 3'd2,
        POP   = 3'd3,
        HOLD  = 3'd4
    } drain_state_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/queue_drain_ctrl.sv
// ----------------------------------------------------------------------------
// queue_drain_ctrl
//   Consumer-side controller for a BITWIDTH x QUEUESIZE command-driven queue.
//   Issues `top` then `dequeue` to the queue, captures the head word and
//   presents it downstream as a valid/ready stream, counting delivered words.
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   enable          : permits starting a new fetch (sampled in IDLE and at
//                     the handshake only)
//   q_is_empty      : queue empty flag
//   q_data          : queue data_out, valid in the cycle after `top`
//   q_top           : queue `top` command, one-cycle pulse
//   q_dequeue       : queue `dequeue` command, one-cycle pulse
//   q_enqueue       : constant 0, this block never writes the queue
//   out_valid       : out_data holds an undelivered word
//   out_data        : delivered word
//   out_ready       : sink ready
//   drained_count   : words delivered since reset, wraps
//   busy            : FSM not in IDLE
//   dbg_state       : current FSM state, for observation only
//
// Stream handshake: a word transfers on a rising edge where out_valid and
// out_ready are both high. out_valid never drops and out_data never changes
// before that transfer; out_ready may toggle freely and has no effect while
// out_valid is low.
//
// Queue contract: q_is_empty is expected to reflect a dequeue issued in the
// same cycle (empty-after-this-cycle). The handshake in POP coincides with
// the dequeue of the last word, and a pre-pop flag there would make the FSM
// issue `top` on an empty queue.
// ----------------------------------------------------------------------------
module queue_drain_ctrl
    import queue_drain_pkg::*;
#(
    parameter int BITWIDTH  = DEF_BITWIDTH,
    parameter int QUEUESIZE = DEF_QUEUESIZE,
    parameter int CNTWIDTH  = $clog2(QUEUESIZE) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                q_is_empty,
    input  logic [BITWIDTH-1:0] q_data,
    output logic                q_top,
    output logic                q_dequeue,
    output logic                q_enqueue,
    output logic                out_valid,
    output logic [BITWIDTH-1:0] out_data,
    input  logic                out_ready,
    output logic [CNTWIDTH-1:0] drained_count,
    output logic                busy,
    output drain_state_t        dbg_state
);

    drain_state_t          state_q, state_d;
    logic                  q_top_q;
    logic                  q_dequeue_q;
    logic                  out_valid_q;
    logic                  busy_q;
    logic [BITWIDTH-1:0]   out_data_q;
    logic [CNTWIDTH-1:0]   count_q;

    logic                  can_fetch;
    logic                  handshake;

    assign can_fetch = enable && !q_is_empty;
    // Both POP and HOLD present a valid word; either may complete the transfer.
    assign handshake = ((state_q == POP) || (state_q == HOLD)) && out_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (can_fetch) state_d = FETCH;
            FETCH: state_d = CAPT;
            CAPT:  state_d = POP;
            POP, HOLD: begin
                if (handshake) begin
                    state_d = can_fetch ? FETCH : IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so that every command and
    // out_valid is a pure function of the registered state, with no
    // combinational path from out_ready or enable to any output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            q_top_q     <= 1'b0;
            q_dequeue_q <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_data_q  <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            q_top_q     <= (state_d == FETCH);
            q_dequeue_q <= (state_d == POP);
            out_valid_q <= (state_d == POP) || (state_d == HOLD);
            busy_q      <= (state_d != IDLE);
            // The queue answers `top` one cycle later, i.e. during CAPT.
            if (state_q == CAPT) begin
                out_data_q <= q_data;
            end
            if (handshake) begin
                count_q <= count_q + CNTWIDTH'(1);
            end
        end
    end

    assign q_top         = q_top_q;
    assign q_dequeue     = q_dequeue_q;
    assign q_enqueue     = 1'b0;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign drained_count = count_q;
    assign busy          = busy_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_queue_drain_ctrl.sv
// ----------------------------------------------------------------------------
// tb_queue_drain_ctrl
//   Bench for queue_drain_ctrl. A behavioural queue (array + pointers) sits on
//   the command side; the bench writes it directly. Every word accepted by the
//   queue is pushed to exp_q, and each delivered word must match its head.
// ----------------------------------------------------------------------------
module tb_queue_drain_ctrl;
  import queue_drain_pkg::*;

  localparam int W  = DEF_BITWIDTH;
  localparam int QS = DEF_QUEUESIZE;
  localparam int CW = $clog2(QS) + 1;
  localparam int PW = $clog2(QS);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic          enable;
  logic          q_is_empty;
  logic [W-1:0]  q_data = '0;
  logic          q_top;
  logic          q_dequeue;
  logic          q_enqueue;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
  logic [CW-1:0] drained_count;
  logic          busy;
  drain_state_t  dbg_state;

  queue_drain_ctrl #(.BITWIDTH(W), .QUEUESIZE(QS), .CNTWIDTH(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .q_is_empty    (q_is_empty),
    .q_data        (q_data),
    .q_top         (q_top),
    .q_dequeue     (q_dequeue),
    .q_enqueue     (q_enqueue),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .drained_count (drained_count),
    .busy          (busy),
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural queue ----------------
  logic [W-1:0]  qmem[QS];
  logic [PW-1:0] q_rd = '0;
  logic [PW-1:0] q_wr = '0;
  int            q_cnt = 0;
  int            pops_total = 0;
  logic          enq = 1'b0;
  logic [W-1:0]  enq_data = '0;

  // Empty flag looks ahead past a dequeue issued this cycle.
  assign q_is_empty = (q_cnt == 0) || (q_cnt == 1 && q_dequeue);

  always @(posedge clk) begin
    if (q_top) q_data <= qmem[q_rd];
    if (q_dequeue && q_cnt != 0) begin
      q_rd       <= q_rd + 1'b1;
      pops_total <= pops_total + 1;
    end
    if (enq && q_cnt < QS) begin
      qmem[q_wr] <= enq_data;
      q_wr       <= q_wr + 1'b1;
      exp_q.push_back(enq_data);
    end
    q_cnt <= q_cnt + ((enq && q_cnt < QS) ? 1 : 0) - ((q_dequeue && q_cnt != 0) ? 1 : 0);
  end

  // ---------------- monitor ----------------
  logic [CW-1:0] model_cnt = '0;
  logic          prev_valid = 1'b0;
  logic          prev_ready = 1'b0;
  logic [W-1:0]  prev_data = '0;
  int            top_n = 0;
  int            deq_n = 0;
  int            delivered_total = 0;
  int            hs_q[$];

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      model_cnt  = '0;
    end else begin
      check("count", 32'(drained_count), 32'(model_cnt));
      check("top_deq_excl", 32'(q_top && q_dequeue), 32'd0);
      check("enq_tied", 32'(q_enqueue), 32'd0);
      check("top_on_empty", 32'(q_top && q_cnt == 0), 32'd0);
      if (prev_valid && !prev_ready) begin
        check("valid_hold", 32'(out_valid), 32'd1);
        check("data_stable", 32'(out_data), 32'(prev_data));
      end
      if (q_top) top_n++;
      if (q_dequeue) deq_n++;
      if (out_valid && out_ready) begin
        hs_q.push_back(cyc);
        delivered_total++;
        if (exp_q.size() == 0) check("extra_word", 32'd1, 32'd0);
        else check("word", 32'(out_data), 32'(exp_q.pop_front()));
        model_cnt = model_cnt + 1'b1;
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_data  = out_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic enq_word(input logic [W-1:0] d);
    int guard = 0;
    while (q_cnt >= QS && guard < 60) begin
      tick();
      guard++;
    end
    if (guard >= 60) check("enq_timeout", 32'd0, 32'd1);
    enq = 1'b1;
    enq_data = d;
    tick();
    enq = 1'b0;
  endtask

  // Waits (bounded) until the queue is empty and the controller has parked.
  task automatic wait_drain(input string tag, input int max);
    int n = 0;
    @(negedge clk);
    while (!(q_cnt == 0 && !busy && !out_valid) && n < max) begin
      @(negedge clk);
      n++;
    end
    if (n >= max) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_valid(input string tag, input int max);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < max) begin
      @(negedge clk);
      n++;
    end
    if (n >= max) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic pulse_reset();
    #1 rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int top0, deq0, cnt0, en_cyc, drop_n;

  initial begin
    enable    = 1'b0;
    out_ready = 1'b0;

    // Reset values.
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_top", 32'(q_top), 32'd0);
    check("rst_deq", 32'(q_dequeue), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_count", 32'(drained_count), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Full queue 0..7, streaming at full rate.
    out_ready = 1'b1;
    for (int i = 0; i < QS; i++) enq_word(W'(i));
    top0 = top_n; deq0 = deq_n;
    hs_q.delete();
    en_cyc = cyc;
    enable = 1'b1;
    wait_drain("fill", 100);
    check("fill_words", 32'(hs_q.size()), 32'd8);
    if (hs_q.size() == 8) begin
      check("fill_latency", 32'(hs_q[0] - en_cyc), 32'd3);
      for (int i = 1; i < 8; i++) check("fill_spacing", 32'(hs_q[i] - hs_q[i-1]), 32'd3);
    end
    check("fill_tops", 32'(top_n - top0), 32'd8);
    check("fill_deqs", 32'(deq_n - deq0), 32'd8);
    check("fill_count", 32'(drained_count), 32'd8);
    check("fill_busy", 32'(busy), 32'd0);
    tick();

    // Backpressure: 5,6 queued, sink stalls for 10 cycles.
    enable = 1'b0;
    out_ready = 1'b0;
    enq_word(W'(5));
    enq_word(W'(6));
    top0 = top_n;
    enable = 1'b1;
    wait_valid("bp", 20);
    check("bp_first", 32'(out_data), 32'd5);
    repeat (10) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", 32'(out_data), 32'd5);
      check("bp_one_top", 32'(top_n - top0), 32'd1);
    end
    tick();
    out_ready = 1'b1;
    wait_drain("bp", 50);
    check("bp_count", 32'(drained_count), 32'd10);
    check("bp_tops", 32'(top_n - top0), 32'd2);
    tick();

    // Empty queue with enable high: nothing happens.
    top0 = top_n; deq0 = deq_n;
    repeat (20) begin
      @(negedge clk);
      check("empty_busy", 32'(busy), 32'd0);
      check("empty_valid", 32'(out_valid), 32'd0);
    end
    check("empty_tops", 32'(top_n - top0), 32'd0);
    check("empty_deqs", 32'(deq_n - deq0), 32'd0);
    tick();

    // Enable dropped during CAPT with three words queued.
    enable = 1'b0;
    enq_word(W'(1));
    enq_word(W'(2));
    enq_word(W'(3));
    cnt0 = delivered_total;
    enable = 1'b1;
    begin
      int n = 0;
      @(negedge clk);
      while (dbg_state != CAPT && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) check("capt_timeout", 32'd0, 32'd1);
    end
    enable = 1'b0;
    repeat (6) @(negedge clk);
    check("park_busy", 32'(busy), 32'd0);
    check("park_left", 32'(q_cnt), 32'd2);
    check("park_delivered", 32'(delivered_total - cnt0), 32'd1);
    tick();
    enable = 1'b1;
    wait_drain("resume", 50);
    check("resume_delivered", 32'(delivered_total - cnt0), 32'd3);
    tick();

    // Reset while a word (4) is held; the queue keeps 7.
    enable = 1'b0;
    out_ready = 1'b0;
    enq_word(W'(4));
    enq_word(W'(7));
    enable = 1'b1;
    wait_valid("hold", 20);
    repeat (2) @(negedge clk);
    check("hold_data", 32'(out_data), 32'd4);
    check("hold_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_data", 32'(out_data), 32'd0);
    check("arst_count", 32'(drained_count), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    // Words the queue gave up but the sink never took are gone.
    drop_n = pops_total - delivered_total;
    repeat (drop_n) if (exp_q.size() != 0) void'(exp_q.pop_front());
    delivered_total = pops_total;
    out_ready = 1'b1;
    wait_drain("after_rst", 50);
    check("after_rst_count", 32'(drained_count), 32'd1);
    tick();

    // Counter wrap after 16 deliveries.
    pulse_reset();
    enable = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) enq_word(W'($urandom_range(0, (1 << W) - 1)));
    wait_drain("wrap", 200);
    check("wrap16", 32'(drained_count), 32'd0);
    tick();
    enq_word(W'($urandom_range(0, (1 << W) - 1)));
    wait_drain("wrap17", 50);
    check("wrap17", 32'(drained_count), 32'd1);
    tick();

    // Randomized traffic: enable, sink readiness and writes all random.
    for (int i = 0; i < 500; i++) begin
      enable    = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      enq       = (q_cnt < QS) && ($urandom_range(0, 1) == 1);
      enq_data  = W'($urandom_range(0, (1 << W) - 1));
      tick();
    end
    enq = 1'b0;
    enable = 1'b1;
    out_ready = 1'b1;
    wait_drain("rand", 200);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    check("rand_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=%0t exp=<500000", $time);
    $fatal(1, "timeout");
  end

endmodule
